exe_iter_divider: RTL

//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the EXE stage.

---
 rtl/exe_iter_divider_if.sv | 29 ++
 rtl/exe_iter_divider.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/exe_iter_divider_if.sv
// Operand/result bundle between the EXE stage and the iterative divider.
// Handshake: the EXE stage raises div_start for one or more cycles while
// div_busy is low; the divider samples div_signed/div_a/div_b on the edge it
// accepts the request and raises div_busy from the next cycle. div_done pulses
// for exactly one cycle when div_quot/div_rem are valid. div_cancel aborts the
// request and wins over div_start.
interface exe_iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_cancel;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    modport master (
        output div_start, div_signed, div_a, div_b, div_cancel,
        input  div_busy, div_done, div_quot, div_rem
    );

    modport slave (
        input  div_start, div_signed, div_a, div_b, div_cancel,
        output div_busy, div_done, div_quot, div_rem
    );
endinterface

// File: rtl/exe_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU. Quotient goes to LO, remainder to HI.
// Operands are reduced to magnitudes up front, divided unsigned over WIDTH
// cycles, then the signs are restored in a single fix-up cycle.
module exe_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    exe_iter_divider_if.slave   div,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] qa_q;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] r_q;       // partial remainder
    logic [WIDTH-1:0] b_abs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   trial;
    logic             accept;
    logic             busy;
    logic             done;

    // Operand magnitudes and the trial subtraction for the current step.
    always_comb begin
        a_abs  = (div.div_signed && div.div_a[WIDTH-1]) ? (WIDTH'(0) - div.div_a) : div.div_a;
        b_abs  = (div.div_signed && div.div_b[WIDTH-1]) ? (WIDTH'(0) - div.div_b) : div.div_b;
        trial  = {r_q, qa_q[WIDTH-1]} - {1'b0, b_abs_q};
        accept = div.div_start && !div.div_cancel;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; cancel overrides every transition.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (div.div_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (div.div_cancel) begin
            state_d = IDLE;
        end
    end

    // Datapath: latch operands, iterate, then write sign-corrected results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            qa_q    <= '0;
            r_q     <= '0;
            b_abs_q <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (div.div_b != '0) begin
                            qa_q    <= a_abs;
                            b_abs_q <= b_abs;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            q_neg_q <= div.div_signed && (div.div_a[WIDTH-1] ^ div.div_b[WIDTH-1]);
                            r_neg_q <= div.div_signed && div.div_a[WIDTH-1];
                        end else begin
                            quot_q <= '1;
                            rem_q  <= div.div_a;
                        end
                    end
                end
                CALC: begin
                    if (!div.div_cancel) begin
                        r_q   <= trial[WIDTH] ? {r_q[WIDTH-2:0], qa_q[WIDTH-1]} : trial[WIDTH-1:0];
                        qa_q  <= {qa_q[WIDTH-2:0], ~trial[WIDTH]};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIX: begin
                    if (!div.div_cancel) begin
                        quot_q <= q_neg_q ? (WIDTH'(0) - qa_q) : qa_q;
                        rem_q  <= r_neg_q ? (WIDTH'(0) - r_q) : r_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div.div_busy = busy;
    assign div.div_done = done;
    assign div.div_quot = quot_q;
    assign div.div_rem  = rem_q;
    assign dbg_state    = state_q;
endmodule
